hilo_mdu: RTL and testbench
===========================

// Module: hilo_mdu
// PURPOSE
// - Parametrised HI/LO unit: holds the HI/LO special registers and owns the multi-cycle
//   multiply/divide datapath that writes them.
// - Adds signed/unsigned MUL, iterative DIV, MADD/MSUB accumulate and MTHI/MTLO single-half writes.
// - Sits beside EX. EX issues via a valid/ready handshake and stalls while busy. HI/LO read by MFHI/MFLO.
// PARAMETERS
// - WIDTH       32  data width of HI, LO and each operand
// - MUL_STAGES  2   MUL/MADD/MSUB occupancy in cycles (1..4); product is retimed across the stages
// - ACC_EN      1   1: MADD/MSUB supported; 0: accepted, no HI/LO write, done still pulses
// PORTS
// - clk        in   1        rising-edge clock
// - rst        in   1        reset: asynchronous assert, active-low
// - req_valid  in   1        operation request
// - req_ready  out  1        combinational: (state==IDLE) && !flush
// - req_op     in   4        hilo_pkg::op_t: MULT,MULTU,DIV,DIVU,MADD,MADDU,MSUB,MSUBU,MTHI,MTLO
// - src_a      in   WIDTH    rs operand / dividend / MTHI-MTLO data
// - src_b      in   WIDTH    rt operand / divisor
// - flush      in   1        synchronous cancel of any in-flight op (exception/branch squash)
// - busy       out  1        state != IDLE
// - done       out  1        registered 1-cycle pulse, high in the first cycle new HI/LO is visible
// - div_zero   out  1        registered; set with done for DIV/DIVU by zero, else 0 with done
// - hi_o       out  WIDTH    HI register
// - lo_o       out  WIDTH    LO register
// BEHAVIOUR
// - Reset (rst low, async): hi_o=lo_o=0, busy=0, done=0, div_zero=0, state=IDLE, counters 0.
// - Accept: req_valid && req_ready at edge t. Operands and op are latched; no other input is sampled until IDLE.
// - States: IDLE, MUL, DIV, FIX.
//   - IDLE->MUL for mul-class ops. IDLE->DIV for div-class ops. MTHI/MTLO stay IDLE.
//   - MUL->IDLE after MUL_STAGES cycles.
//   - DIV->FIX after WIDTH cycles. FIX->IDLE after 1 cycle.
// - Latency, new HI/LO visible at:
//   - MTHI/MTLO: t+1 (writes only the addressed half).
//   - MUL-class: t+MUL_STAGES+1.
//   - DIV-class: t+WIDTH+2.
// - Multiply: 2*WIDTH-bit product; signed for MULT/MADD/MSUB, unsigned for *U variants. {HI,LO}=product.
// - Accumulate: {HI,LO} = {HI,LO} +/- product, mod 2^(2*WIDTH).
//   - Uses the HI/LO value held at the final MUL cycle.
// - Divide: restoring radix-2, one quotient bit per DIV cycle.
//   - Signed ops work on magnitudes; FIX negates the quotient if operand signs differ.
//   - Remainder takes the sign of the dividend.
//   - LO=quotient, HI=remainder.
//   - MIN/-1 gives LO=MIN, HI=0, with no flag.
// - Divide by zero: full latency is still consumed; HI/LO unchanged; div_zero=1 with done.
// - flush in a non-IDLE state: next state IDLE, no HI/LO write, no done.
//   - flush in IDLE blocks acceptance that cycle.
//   - flush has priority over completion in the final MUL/FIX cycle.
// - done and hi_o/lo_o update on the same edge. req_ready can rise in that same cycle (back-to-back ok).
// - No bypass: hi_o/lo_o are pure register outputs. EX forwards from its own pipeline.
// - rst mid-operation: immediate return to reset values; partial results discarded.
// STRUCTURE
// - hilo_pkg: op_t enum (4-bit), state_t enum, helpers is_mul(op), is_div(op), is_signed(op), is_acc(op).
// - Sub-module hilo_div_core: iterative divider (start, a, b, signed; busy, quot, rem),
//   WIDTH iterations plus sign fix.
// - Multiplier and HI/LO update logic live in hilo_mdu.
// TESTING
// - Reset: hold rst low 3 cycles, then release -> hi_o=lo_o=0, busy=0, req_ready=1.
// - MULT a=0xFFFFFFFE(-2), b=3 -> at t+3 (MUL_STAGES=2): HI=0xFFFFFFFF, LO=0xFFFFFFFA, done=1.
//   - MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
// - Sequence MTHI 0, MTLO 10, then MADD a=5,b=4 -> LO=30, HI=0.
//   - Then MSUBU a=1,b=31 -> {HI,LO}=0xFFFFFFFF_FFFFFFFF.
// - DIV a=-7, b=2 -> at t+34: LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1).
//   - DIVU a=7,b=2 -> LO=3, HI=1.
//   - DIV a=0x80000000, b=-1 -> LO=0x80000000, HI=0.
// - DIVU by 0 with HI=0x11, LO=0x22 -> busy for 33 cycles; done with div_zero=1; HI/LO unchanged.
// - flush in DIV cycle 10 -> IDLE next cycle, no done, HI/LO unchanged.
//   - flush with req_valid in IDLE -> req_ready=0, op not taken.
//   - Back-to-back MULT issued in the done cycle -> accepted.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types and opcode classifiers for the HI/LO multiply/divide unit.
package hilo_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    function automatic logic is_mul(input op_t op);
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul = 1'b1;
            default:                                                is_mul = 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input op_t op);
        case (op)
            OP_DIV, OP_DIVU: is_div = 1'b1;
            default:         is_div = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed(input op_t op);
        case (op)
            OP_MULT, OP_DIV, OP_MADD, OP_MSUB: is_signed = 1'b1;
            default:                           is_signed = 1'b0;
        endcase
    endfunction

    function automatic logic is_acc(input op_t op);
        case (op)
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_acc = 1'b1;
            default:                              is_acc = 1'b0;
        endcase
    endfunction

    function automatic logic is_sub(input op_t op);
        case (op)
            OP_MSUB, OP_MSUBU: is_sub = 1'b1;
            default:           is_sub = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hilo_mdu_div_core.sv
// Iterative restoring radix-2 divider: one quotient bit per cycle on operand
// magnitudes; signs are reapplied combinationally on the held result.
module hilo_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             last_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             run_q, run_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic             a_neg_s, b_neg_s, fits_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s, diff_s;
    logic [WIDTH:0]   shift_s;

    // Operand magnitudes and one restoring-division step.
    always_comb begin
        a_neg_s = signed_i & a_i[WIDTH-1];
        b_neg_s = signed_i & b_i[WIDTH-1];
        a_mag_s = a_neg_s ? (-a_i) : a_i;
        b_mag_s = b_neg_s ? (-b_i) : b_i;
        shift_s = {r_q, q_q[WIDTH-1]};
        fits_s  = (shift_s >= {1'b0, d_q});
        diff_s  = shift_s[WIDTH-1:0] - d_q;
    end

    // Next-state for the iteration registers.
    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        q_d    = q_q;
        r_d    = r_q;
        d_d    = d_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (start_i) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            q_d    = a_mag_s;
            r_d    = '0;
            d_d    = b_mag_s;
            qneg_d = a_neg_s ^ b_neg_s;
            rneg_d = a_neg_s;
        end else if (run_q) begin
            if (flush_i) begin
                run_d = 1'b0;
            end else begin
                q_d = {q_q[WIDTH-2:0], fits_s};
                r_d = fits_s ? diff_s : shift_s[WIDTH-1:0];
                if (cnt_q == LAST) begin
                    run_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Iteration state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            q_q    <= '0;
            r_q    <= '0;
            d_q    <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            r_q    <= r_d;
            d_q    <= d_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end

    assign busy_o = run_q;
    assign last_o = run_q && (cnt_q == LAST);
    // MIN / -1 wraps back to MIN here, which is the architected result.
    assign quot_o = qneg_q ? (-q_q) : q_q;
    assign rem_o  = rneg_q ? (-r_q) : r_q;

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO special registers plus the multi-cycle multiply/accumulate/divide
// datapath that updates them; issued from EX through a valid/ready handshake.
module hilo_mdu
    import hilo_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2,
    parameter int ACC_EN     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int PW = 2 * WIDTH;
    localparam logic [2:0] MUL_LAST = 3'(MUL_STAGES - 1);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic             bz_q, bz_d;

    op_t              req_op_s;
    logic             accept_s;
    logic [PW-1:0]    ext_a_s, ext_b_s, prod_s, mul_res_s, mul_wr_s;
    logic             div_busy_s, div_last_s;
    logic [WIDTH-1:0] div_quot_s, div_rem_s;

    assign req_op_s  = op_t'(req_op);
    assign req_ready = (state_q == ST_IDLE) && !flush;
    assign accept_s  = req_valid && req_ready;

    // Extend latched operands to full product width per signedness.
    always_comb begin
        if (is_signed(op_q)) begin
            ext_a_s = {{WIDTH{a_q[WIDTH-1]}}, a_q};
            ext_b_s = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end else begin
            ext_a_s = {{WIDTH{1'b0}}, a_q};
            ext_b_s = {{WIDTH{1'b0}}, b_q};
        end
        prod_s = ext_a_s * ext_b_s;
    end

    // Delay chain lets synthesis retime the multiplier over the MUL stages.
    generate
        if (MUL_STAGES == 1) begin : g_nopipe
            assign mul_res_s = prod_s;
        end else begin : g_pipe
            logic [MUL_STAGES-2:0][PW-1:0] pipe_q;
            // Product pipeline registers.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q[0] <= prod_s;
                    for (int i = 1; i < MUL_STAGES - 1; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end
            assign mul_res_s = pipe_q[MUL_STAGES-2];
        end
    endgenerate

    // Value written to {HI,LO} by a mul-class op; HI/LO are stable while busy.
    always_comb begin
        if (!is_acc(op_q)) begin
            mul_wr_s = mul_res_s;
        end else if (is_sub(op_q)) begin
            mul_wr_s = {hi_q, lo_q} - mul_res_s;
        end else begin
            mul_wr_s = {hi_q, lo_q} + mul_res_s;
        end
    end

    hilo_div_core #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start_i  (accept_s && is_div(req_op_s)),
        .flush_i  (flush),
        .signed_i (is_signed(req_op_s)),
        .a_i      (src_a),
        .b_i      (src_b),
        .busy_o   (div_busy_s),
        .last_o   (div_last_s),
        .quot_o   (div_quot_s),
        .rem_o    (div_rem_s)
    );

    // Control FSM next-state and HI/LO update.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        bz_d    = bz_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d  = req_op_s;
                    a_d   = src_a;
                    b_d   = src_b;
                    cnt_d = 3'd0;
                    bz_d  = (src_b == {WIDTH{1'b0}});
                    if (is_mul(req_op_s)) begin
                        state_d = ST_MUL;
                    end else if (is_div(req_op_s)) begin
                        state_d = ST_DIV;
                    end else if (req_op_s == OP_MTHI) begin
                        hi_d   = src_a;
                        done_d = 1'b1;
                    end else if (req_op_s == OP_MTLO) begin
                        lo_d   = src_a;
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (!(is_acc(op_q) && (ACC_EN == 0))) begin
                        {hi_d, lo_d} = mul_wr_s;
                    end else begin
                        {hi_d, lo_d} = {hi_q, lo_q};
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (div_last_s || !div_busy_s) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (flush) begin
                    done_d = 1'b0;
                end else if (bz_q) begin
                    done_d = 1'b1;
                    dz_d   = 1'b1;
                end else begin
                    done_d = 1'b1;
                    hi_d   = div_rem_s;
                    lo_d   = div_quot_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and architectural registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= 3'd0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            bz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            bz_q    <= bz_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu (WIDTH=32, MUL_STAGES=2, ACC_EN=1).
module tb_hilo_mdu;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, flush, busy, done, div_zero;
    logic [3:0]  req_op;
    logic [31:0] src_a, src_b, hi_o, lo_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mhi = 32'd0, mlo = 32'd0;
    logic        exp_dz;
    int          exp_lat;

    always #5 clk = ~clk;

    hilo_mdu #(.WIDTH(32), .MUL_STAGES(2), .ACC_EN(1)) dut (
        .clk(clk), .rst(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .done(done), .div_zero(div_zero), .hi_o(hi_o), .lo_o(lo_o)
    );

    // Architectural reference: what HI/LO must become after one op.
    function automatic void model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] acc, sp, up, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        up = {32'd0, a} * {32'd0, b};
        acc = {mhi, mlo};
        exp_dz = 1'b0;
        exp_lat = 3;
        case (op)
            OP_MULT:  acc = sp;
            OP_MULTU: acc = up;
            OP_MADD:  acc = acc + sp;
            OP_MADDU: acc = acc + up;
            OP_MSUB:  acc = acc - sp;
            OP_MSUBU: acc = acc - up;
            OP_DIV, OP_DIVU: begin
                exp_lat = 34;
                if (b == 32'd0) begin
                    exp_dz = 1'b1;
                end else if (op == OP_DIV) begin
                    qv = sa / sb;
                    rv = sa % sb;
                    acc = {rv[31:0], qv[31:0]};
                end else begin
                    acc = {a % b, a / b};
                end
            end
            OP_MTHI: begin acc[63:32] = a; exp_lat = 1; end
            OP_MTLO: begin acc[31:0] = a; exp_lat = 1; end
            default: exp_lat = 1;
        endcase
        {mhi, mlo} = acc;
    endfunction

    // Present a request at a negedge; it is taken at the following posedge.
    task automatic drive_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcyc, output logic dz, output bit seen);
        lat = 0; bcyc = 0; dz = 1'b0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin seen = 1'b1; dz = div_zero; break; end
            if (busy) bcyc++;
        end
    endtask

    task automatic exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcyc, output logic dz, output bit seen);
        @(negedge clk);
        for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
        model_apply(op, a, b);
        drive_req(op, a, b);
        wait_done(lat, bcyc, dz, seen);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; req_op = 4'd0; src_a = 32'd0; src_b = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        n_checks++; if ({hi_o, lo_o} !== 64'd0) $display("FAIL reset_hilo got %h exp 0", {hi_o, lo_o}); else n_pass++;
        n_checks++; if ({busy, done, div_zero, req_ready} !== 4'b0001) $display("FAIL reset_ctl got %b exp 0001", {busy, done, div_zero, req_ready}); else n_pass++;
    endtask

    task automatic test_mul();
        int lat, bc; logic dz; bit seen;
        exec(OP_MULT, 32'hFFFFFFFE, 32'd3, lat, bc, dz, seen);
        n_checks++; if (!seen || lat != 3) $display("FAIL mult_latency got %0d seen %0d exp 3", lat, seen); else n_pass++;
        n_checks++; if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFFA) $display("FAIL mult_value got %h exp ffffffff_fffffffa", {hi_o, lo_o}); else n_pass++;
        exec(OP_MULTU, 32'hFFFFFFFE, 32'd3, lat, bc, dz, seen);
        n_checks++; if ({hi_o, lo_o} !== 64'h00000002_FFFFFFFA) $display("FAIL multu_value got %h exp 00000002_fffffffa", {hi_o, lo_o}); else n_pass++;
    endtask

    task automatic test_acc();
        int lat, bc; logic dz; bit seen;
        exec(OP_MTHI, 32'd0, 32'd0, lat, bc, dz, seen);
        n_checks++; if (!seen || lat != 1) $display("FAIL mthi_latency got %0d seen %0d exp 1", lat, seen); else n_pass++;
        exec(OP_MTLO, 32'd10, 32'd0, lat, bc, dz, seen);
        exec(OP_MADD, 32'd5, 32'd4, lat, bc, dz, seen);
        n_checks++; if ({hi_o, lo_o} !== 64'd30) $display("FAIL madd_value got %h exp 30", {hi_o, lo_o}); else n_pass++;
        exec(OP_MSUBU, 32'd1, 32'd31, lat, bc, dz, seen);
        n_checks++; if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFFF) $display("FAIL msubu_value got %h exp all ones", {hi_o, lo_o}); else n_pass++;
    endtask

    task automatic test_div();
        int lat, bc; logic dz; bit seen;
        exec(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bc, dz, seen);
        n_checks++; if (!seen || lat != 34 || dz !== 1'b0) $display("FAIL div_latency got %0d dz %b exp 34 dz 0", lat, dz); else n_pass++;
        n_checks++; if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL div_neg got %h exp ffffffff_fffffffd", {hi_o, lo_o}); else n_pass++;
        exec(OP_DIVU, 32'd7, 32'd2, lat, bc, dz, seen);
        n_checks++; if ({hi_o, lo_o} !== 64'h00000001_00000003) $display("FAIL divu_value got %h exp 00000001_00000003", {hi_o, lo_o}); else n_pass++;
        exec(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc, dz, seen);
        n_checks++; if ({hi_o, lo_o, dz} !== {64'h00000000_80000000, 1'b0}) $display("FAIL div_min got %h dz %b exp 00000000_80000000 dz 0", {hi_o, lo_o}, dz); else n_pass++;
    endtask

    task automatic test_div_zero();
        int lat, bc; logic dz; bit seen;
        exec(OP_MTHI, 32'h11, 32'd0, lat, bc, dz, seen);
        exec(OP_MTLO, 32'h22, 32'd0, lat, bc, dz, seen);
        exec(OP_DIVU, 32'd5, 32'd0, lat, bc, dz, seen);
        n_checks++; if (!seen || bc != 33 || lat != 34) $display("FAIL divz_busy got busy %0d lat %0d exp 33/34", bc, lat); else n_pass++;
        n_checks++; if (dz !== 1'b1) $display("FAIL divz_flag got %b exp 1", dz); else n_pass++;
        n_checks++; if ({hi_o, lo_o} !== 64'h00000011_00000022) $display("FAIL divz_hilo got %h exp 00000011_00000022", {hi_o, lo_o}); else n_pass++;
        @(negedge clk);
        n_checks++; if (div_zero !== 1'b0) $display("FAIL divz_pulse got %b exp 0", div_zero); else n_pass++;
    endtask

    task automatic test_flush();
        int lat, bc, n_done; logic dz; bit seen;
        exec(OP_MTHI, 32'hAA, 32'd0, lat, bc, dz, seen);
        exec(OP_MTLO, 32'hBB, 32'd0, lat, bc, dz, seen);
        @(negedge clk);
        drive_req(OP_DIV, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL flush_idle got busy %b exp 0", busy); else n_pass++;
        n_done = 0;
        repeat (40) begin @(negedge clk); if (done) n_done++; end
        n_checks++; if (n_done != 0) $display("FAIL flush_nodone got %0d exp 0", n_done); else n_pass++;
        n_checks++; if ({hi_o, lo_o} !== 64'h000000AA_000000BB) $display("FAIL flush_hilo got %h exp 000000aa_000000bb", {hi_o, lo_o}); else n_pass++;
        flush = 1'b1; req_valid = 1'b1; req_op = OP_MTHI; src_a = 32'h55;
        #1;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL flush_ready got %b exp 0", req_ready); else n_pass++;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({done, busy, hi_o} !== {2'b00, 32'hAA}) $display("FAIL flush_noaccept got %b %h exp 00 000000aa", {done, busy}, hi_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat, bc; logic dz; bit seen;
        exec(OP_MULT, 32'd7, 32'd6, lat, bc, dz, seen);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", req_ready); else n_pass++;
        model_apply(OP_MULT, 32'd3, 32'hFFFFFFFB);
        drive_req(OP_MULT, 32'd3, 32'hFFFFFFFB);
        wait_done(lat, bc, dz, seen);
        n_checks++; if (!seen || lat != 3) $display("FAIL b2b_latency got %0d seen %0d exp 3", lat, seen); else n_pass++;
        n_checks++; if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFF1) $display("FAIL b2b_value got %h exp ffffffff_fffffff1", {hi_o, lo_o}); else n_pass++;
    endtask

    task automatic test_random();
        int lat, bc, sel; logic dz; bit seen;
        logic [3:0] op; logic [31:0] a, b;
        for (int k = 0; k < 30; k++) begin
            op  = 4'($urandom_range(9, 0));
            a   = $urandom;
            sel = $urandom_range(7, 0);
            if (sel == 0)      b = 32'd0;
            else if (sel < 3)  b = 32'($urandom_range(15, 1));
            else if (sel == 3) b = -32'($urandom_range(15, 1));
            else               b = $urandom;
            exec(op, a, b, lat, bc, dz, seen);
            n_checks++; if (!seen || lat != exp_lat) $display("FAIL rnd_latency op %0d got %0d exp %0d", op, lat, exp_lat); else n_pass++;
            n_checks++; if ({hi_o, lo_o} !== {mhi, mlo}) $display("FAIL rnd_value op %0d a %h b %h got %h exp %h", op, a, b, {hi_o, lo_o}, {mhi, mlo}); else n_pass++;
            n_checks++; if (dz !== exp_dz) $display("FAIL rnd_divzero op %0d got %b exp %b", op, dz, exp_dz); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc; logic dz; bit seen;
        exec(OP_MTHI, 32'h1234, 32'd0, lat, bc, dz, seen);
        @(negedge clk);
        drive_req(OP_DIV, 32'd99, 32'd5);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if ({busy, done, hi_o, lo_o} !== 66'd0) $display("FAIL rst_mid got busy %b hi %h lo %h exp all 0", busy, hi_o, lo_o); else n_pass++;
        mhi = 32'd0; mlo = 32'd0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_acc();
        test_div();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
